// File: rtl/neuron_lut_arbiter.sv
// Round-robin arbiter that shares one combinational LUT neuron among NUM_REQ requesters.
// Optional macro NEURON_LUT_OUT_REG_EN adds a register on lut_data (latency 3 instead of 2).
module neuron_lut_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         lut_addr,
  input  logic [DATA_W-1:0]         lut_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [15:0]               grant_cnt
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   grant_cnt_q, grant_cnt_d;
  logic [ADDR_W-1:0]  lut_addr_q, lut_addr_d;
  logic               s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0]   s1_tag_q, s1_tag_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;

  logic               grant_vld_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic [IDX_W:0]     cand_c;
  logic               rsp_src_vld;
  logic [IDX_W-1:0]   rsp_src_tag;
  logic [DATA_W-1:0]  rsp_src_data;

`ifdef NEURON_LUT_OUT_REG_EN
  logic               s2_vld_q, s2_vld_d;
  logic [IDX_W-1:0]   s2_tag_q, s2_tag_d;
  logic [DATA_W-1:0]  lut_data_q, lut_data_d;
`endif

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    cand_c      = '0;
    req_ready   = '0;
    if (rst_n && en) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand_c = {1'b0, last_grant_q} + (IDX_W+1)'(k);
        if (cand_c >= (IDX_W+1)'(NUM_REQ)) begin
          cand_c = cand_c - (IDX_W+1)'(NUM_REQ);
        end
        if (!grant_vld_c && req_valid[cand_c[IDX_W-1:0]]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = cand_c[IDX_W-1:0];
        end
      end
      if (grant_vld_c) begin
        req_ready[grant_idx_c] = 1'b1;
      end
    end
  end

  // Response source: either the live LUT output or its registered copy.
`ifdef NEURON_LUT_OUT_REG_EN
  always_comb begin
    s2_vld_d   = s1_vld_q;
    s2_tag_d   = s2_tag_q;
    lut_data_d = lut_data_q;
    if (s1_vld_q) begin
      s2_tag_d   = s1_tag_q;
      lut_data_d = lut_data;
    end
    rsp_src_vld  = s2_vld_q;
    rsp_src_tag  = s2_tag_q;
    rsp_src_data = lut_data_q;
  end
`else
  always_comb begin
    rsp_src_vld  = s1_vld_q;
    rsp_src_tag  = s1_tag_q;
    rsp_src_data = lut_data;
  end
`endif

  // Next-state for arbiter pointer, counter and pipeline.
  always_comb begin
    last_grant_d = last_grant_q;
    grant_cnt_d  = grant_cnt_q;
    lut_addr_d   = lut_addr_q;
    s1_vld_d     = 1'b0;
    s1_tag_d     = s1_tag_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    if (grant_vld_c) begin
      last_grant_d = grant_idx_c;
      lut_addr_d   = req_addr[grant_idx_c*ADDR_W +: ADDR_W];
      s1_vld_d     = 1'b1;
      s1_tag_d     = grant_idx_c;
      if (grant_cnt_q != CNT_MAX) begin
        grant_cnt_d = grant_cnt_q + CNT_W'(1);
      end
    end
    if (rsp_src_vld) begin
      rsp_valid_d = NUM_REQ'(1) << rsp_src_tag;
      rsp_data_d  = rsp_src_data;
    end
`ifdef NEURON_LUT_OUT_REG_EN
    busy_d = s1_vld_d | s2_vld_d | rsp_src_vld;
`else
    busy_d = s1_vld_d | rsp_src_vld;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= LAST_IDX;
      grant_cnt_q  <= '0;
      lut_addr_q   <= '0;
      s1_vld_q     <= 1'b0;
      s1_tag_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_cnt_q  <= grant_cnt_d;
      lut_addr_q   <= lut_addr_d;
      s1_vld_q     <= s1_vld_d;
      s1_tag_q     <= s1_tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
    end
  end

`ifdef NEURON_LUT_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q   <= 1'b0;
      s2_tag_q   <= '0;
      lut_data_q <= '0;
    end else begin
      s2_vld_q   <= s2_vld_d;
      s2_tag_q   <= s2_tag_d;
      lut_data_q <= lut_data_d;
    end
  end
`endif

  assign lut_addr  = lut_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_neuron_lut_arbiter.sv
// Bench for neuron_lut_arbiter: behavioural model checked every cycle plus directed literal checks.
module tb_neuron_lut_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 1;
`ifdef NEURON_LUT_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      en = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         lut_addr;
  logic [DATA_W-1:0]         lut_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;
  logic [15:0]               grant_cnt;

  logic [DATA_W-1:0] lut_mem [256];

  int checks = 0;
  int failures = 0;

  neuron_lut_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .lut_addr(lut_addr), .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .grant_cnt(grant_cnt)
  );

  assign lut_data = lut_mem[lut_addr];

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Model state: who was granted k cycles ago, and what that implies for the outputs now.
  int          m_last   = NUM_REQ - 1;
  int          m_cnt    = 0;
  logic [7:0]  m_addr   = '0;
  bit          h_v   [1:3];
  int          h_id  [1:3];
  logic [7:0]  h_addr[1:3];

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    int exp_id;
    logic [NUM_REQ-1:0] exp_rsp;
    bit exp_busy;
    if (!rst_n) begin
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_lut_addr", 32'(lut_addr), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant_cnt", 32'(grant_cnt), 0);
      m_last = NUM_REQ - 1;
      m_cnt  = 0;
      m_addr = '0;
      for (int k = 1; k <= 3; k++) h_v[k] = 1'b0;
    end else begin
      exp_ready = '0;
      exp_id = -1;
      if (en) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (exp_id < 0 && req_valid[(m_last + k) % NUM_REQ]) exp_id = (m_last + k) % NUM_REQ;
        end
      end
      if (exp_id >= 0) exp_ready[exp_id] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("lut_addr", 32'(lut_addr), 32'(m_addr));
      check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
      exp_rsp = h_v[LAT] ? (NUM_REQ'(1) << h_id[LAT]) : '0;
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (h_v[LAT]) check("rsp_data", 32'(rsp_data), 32'(lut_mem[h_addr[LAT]]));
      exp_busy = 1'b0;
      for (int k = 1; k <= LAT; k++) exp_busy = exp_busy | h_v[k];
      check("busy", 32'(busy), 32'(exp_busy));
      for (int k = 3; k >= 2; k--) begin
        h_v[k] = h_v[k-1]; h_id[k] = h_id[k-1]; h_addr[k] = h_addr[k-1];
      end
      h_v[1] = (exp_id >= 0);
      if (exp_id >= 0) begin
        h_id[1]   = exp_id;
        h_addr[1] = req_addr[exp_id*ADDR_W +: ADDR_W];
        m_addr    = h_addr[1];
        m_last    = exp_id;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = 8'($urandom);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    en = 1'b0;
    req_valid = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) lut_mem[a] = DATA_W'($urandom);
    lut_mem[8'hA0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin h_v[k] = 1'b0; h_id[k] = 0; h_addr[k] = '0; end

    // Single request from requester 2 at address A0.
    do_reset();
    step();
    en = 1'b1; rand_addrs(); req_addr[2*ADDR_W +: ADDR_W] = 8'hA0; req_valid = 4'b0100;
    @(negedge clk); check("single_ready_c0", 32'(req_ready), 32'h4);
    step(); req_valid = '0; rand_addrs();
    @(negedge clk); check("single_lut_addr_c1", 32'(lut_addr), 32'hA0);
    for (int c = 2; c <= LAT; c++) begin
      step();
      @(negedge clk);
      if (c < LAT) check("single_rsp_early", 32'(rsp_valid), 0);
      else begin
        check("single_rsp_valid", 32'(rsp_valid), 32'h4);
        check("single_rsp_data", 32'(rsp_data), 1);
      end
    end
    repeat (3) step();

    // All four valid for eight cycles after reset: strict rotation.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(); req_valid = '1; rand_addrs();
      @(negedge clk); check("rr_order", 32'(req_ready), 32'(1 << (k % 4)));
    end
    step(); req_valid = '0;
    @(negedge clk); check("rr_grant_cnt", 32'(grant_cnt), 8);

    // en dropped the cycle after an accept.
    step(); req_valid = '1; rand_addrs();
    @(negedge clk); check("drain_accept", 32'(req_ready), 32'h1);
    step(); en = 1'b0;
    @(negedge clk); check("drain_no_ready", 32'(req_ready), 0);
    for (int c = 2; c <= LAT + 1; c++) begin
      step();
      @(negedge clk);
      check("drain_no_ready", 32'(req_ready), 0);
      if (c == LAT) begin
        check("drain_rsp_valid", 32'(rsp_valid), 32'h1);
        check("drain_busy_hi", 32'(busy), 1);
      end
      if (c == LAT + 1) check("drain_busy_lo", 32'(busy), 0);
    end

    // Reset with lookups in flight.
    step(); en = 1'b1; req_valid = '1;
    step();
    do_reset();
    @(negedge clk);
    check("postrst_rsp_valid", 32'(rsp_valid), 0);
    check("postrst_busy", 32'(busy), 0);
    step(); en = 1'b1; req_valid = '1; rand_addrs();
    @(negedge clk); check("postrst_first_grant", 32'(req_ready), 32'h1);
    step(); req_valid = '0;
    repeat (LAT + 2) step();

    // Randomized traffic with en toggling and addresses churning on idle requesters.
    for (int c = 0; c < 3000; c++) begin
      step();
      en = ($urandom_range(0, 9) != 0);
      req_valid = NUM_REQ'($urandom);
      rand_addrs();
    end
    step(); req_valid = '0;
    repeat (LAT + 2) step();

    // Long back-to-back run from one requester to saturate the counter.
    en = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      step(); req_valid = 4'b0010; rand_addrs();
    end
    step(); req_valid = '0;
    @(negedge clk); check("sat_grant_cnt", 32'(grant_cnt), 32'hFFFF);
    repeat (LAT + 2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
